icache_nway: RTL and testbench
==============================

// Module: icache_nway
// PURPOSE
//  Next-generation L1 instruction cache between the fetch stage and the memory interconnect.
//  Blocking; any power-of-2 associativity, including direct-mapped.
//  Per-set round-robin replacement, single-request line-burst refill, critical-word forwarding.
//  Multi-cycle set-sweep flush with a done pulse; saturating hit/miss counters.
// PARAMETERS
//  CACHE_SIZE  4096  total data capacity in bytes (power of 2)
//  LINE_SIZE   32    line size in bytes (power of 2, >= DATA_WIDTH/8)
//  WAYS        2     associativity (power of 2, >= 1)
//  ADDR_WIDTH  32    physical address width
//  DATA_WIDTH  32    fetch word / memory beat width (power of 2, >= 8)
//  Derived: WPL=LINE_SIZE/(DATA_WIDTH/8); SETS=CACHE_SIZE/(LINE_SIZE*WAYS).
//  Elaboration $error if any power-of-2 rule fails or SETS<1.
// PORTS
//  clk_i              in   1           clock
//  rst_i              in   1           reset
//  cpu_req_valid_i    in   1           fetch request valid
//  cpu_req_addr_i     in   ADDR_WIDTH  fetch address (word aligned; low bits ignored)
//  cpu_req_ready_o    out  1           request accepted when valid&ready
//  cpu_rsp_valid_o    out  1           response valid (one-cycle pulse)
//  cpu_rsp_data_o     out  DATA_WIDTH  response word
//  cpu_rsp_hit_o      out  1           1=served from array, 0=forwarded from refill
//  mem_req_valid_o    out  1           line refill request
//  mem_req_addr_o     out  ADDR_WIDTH  line-aligned refill address
//  mem_req_ready_i    in   1           memory accepts request
//  mem_rsp_valid_i    in   1           refill beat valid; beats arrive in order, word 0 first
//  mem_rsp_data_i     in   DATA_WIDTH  refill beat data
//  flush_i            in   1           invalidate-all request (level)
//  flush_done_o       out  1           one-cycle pulse when flush completes
//  perf_hit_count_o   out  32          hits, saturating at 32'hFFFF_FFFF
//  perf_miss_count_o  out  32          misses, saturating
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset: state=IDLE; all valid bits, RR pointers, counters and pending flush cleared.
//  Reset: every output 0, except cpu_req_ready_o=1 once rst_i deasserts.
//  Reset mid-refill abandons the line (its way stays invalid). Beats arriving in IDLE are ignored.
//  States: IDLE, LOOKUP, REFILL_REQ, REFILL, FLUSH.
//  IDLE
//   - flush_i or pending flush -> FLUSH; ready=0 this cycle.
//   - Else ready=1; on accept, latch addr -> LOOKUP.
//  LOOKUP
//   - Tag compare across all ways.
//   - Hit: rsp_valid=1, hit=1, data=word; latency 1 cycle after accept.
//     ready=1 (unless flush_i); a new accept stays in LOOKUP, giving 1 fetch/cycle on hits.
//   - Miss: victim = lowest-index invalid way, else set RR pointer; -> REFILL_REQ.
//   - Multiple-way match cannot occur; assertion only.
//  REFILL_REQ
//   - mem_req_valid_o=1, addr={tag,index,0}; held stable until mem_req_ready_i -> REFILL.
//  REFILL
//   - Beat counter 0..WPL-1; each beat written to the victim way.
//   - On beat index == requested word: rsp_valid=1, hit=0, data=mem_rsp_data_i, same cycle.
//   - On last beat: set valid and tag; RR pointer of that set += 1 (mod WAYS) only if all ways
//     were valid at miss time; -> IDLE.
//   - cpu_req_ready_o=0 throughout REFILL_REQ and REFILL.
//  Flush
//   - flush_i asserted in REFILL_REQ/REFILL/LOOKUP-miss sets a pending flag; honoured on return to IDLE.
//   - FLUSH clears valid bits and RR pointer of one set per cycle, set 0..SETS-1: SETS cycles.
//   - flush_done_o pulses the cycle after the last set is cleared; then IDLE.
//   - flush_i high during FLUSH is absorbed (no second flush). flush_i with a request in IDLE: flush wins.
//  Counters
//   - +1 hit per LOOKUP hit, +1 miss per LOOKUP miss; hold at max, no wrap.
// TESTING
//  Bench config: CACHE_SIZE=256, LINE_SIZE=16, WAYS=2, DATA_WIDTH=32 -> SETS=8, WPL=4.
//  1. Cold fetch 0x108:
//     -> mem_req addr 0x100; beats A0..A3; rsp on 3rd beat data=A2 hit=0; miss=1.
//  2. Back-to-back fetches 0x108, 0x10C after test 1:
//     -> rsp at cycles t+1, t+2 = A2, A3, hit=1; ready never drops; hit=2.
//  3. Fetch 0x100, 0x180, 0x200 (all set 0):
//     -> third evicts way 0 (0x100); fetch 0x180 hits; fetch 0x100 misses and evicts way 1 (0x180).
//  4. flush_i one cycle in IDLE:
//     -> ready=0 for 8 cycles, flush_done_o pulse; fetch 0x108 misses.
//  5. flush_i during REFILL beat 1:
//     -> refill completes and critical word forwarded; FLUSH starts next cycle; line gone afterwards.
//  6. rst_i during REFILL beat 2; then fetch 0x100:
//     -> outputs 0 in reset, stray beats ignored; fetch 0x100 misses and refetches 0x100.

Source files
------------

// File: rtl/icache_nway.sv
// icache_nway: blocking L1 instruction cache with N-way set associativity.
//   Lookup takes one cycle after accept; hits stream at one fetch per cycle.
//   A miss picks a victim (lowest invalid way, else the set's round-robin
//   pointer) and issues one line-burst request. The requested word is
//   forwarded to the fetch stage as soon as its beat arrives.
//   A flush sweeps one set per cycle and pulses flush_done_o when finished.
//   Saturating hit/miss counters are provided for performance monitoring.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   cpu_req_valid_i/addr_i/ready_o    fetch request handshake
//   cpu_rsp_valid_o/data_o/hit_o      one-cycle fetch response
//   mem_req_valid_o/addr_o/ready_i    line refill request handshake
//   mem_rsp_valid_i/data_i            refill beats, word 0 first
//   flush_i, flush_done_o             invalidate-all request / completion pulse
//   perf_hit_count_o/miss_count_o     saturating event counters
module icache_nway #(
  parameter int CACHE_SIZE = 4096,
  parameter int LINE_SIZE  = 32,
  parameter int WAYS       = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpu_req_valid_i,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr_i,
  output logic                  cpu_req_ready_o,
  output logic                  cpu_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] cpu_rsp_data_o,
  output logic                  cpu_rsp_hit_o,
  output logic                  mem_req_valid_o,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_req_ready_i,
  input  logic                  mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
  input  logic                  flush_i,
  output logic                  flush_done_o,
  output logic [31:0]           perf_hit_count_o,
  output logic [31:0]           perf_miss_count_o
);

  localparam int BPW       = DATA_WIDTH / 8;
  localparam int WPL       = LINE_SIZE / BPW;
  localparam int SETS      = CACHE_SIZE / (LINE_SIZE * WAYS);
  localparam int BYTE_BITS = $clog2(BPW);
  localparam int OFF_BITS  = $clog2(LINE_SIZE);
  localparam int IDX_BITS  = (SETS > 1) ? $clog2(SETS) : 0;
  localparam int IDX_W     = (SETS > 1) ? IDX_BITS : 1;
  localparam int WORD_W    = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W     = ADDR_WIDTH - OFF_BITS - IDX_BITS;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  generate
    if (!is_pow2(CACHE_SIZE) || !is_pow2(LINE_SIZE) || !is_pow2(WAYS) ||
        !is_pow2(DATA_WIDTH) || (DATA_WIDTH < 8) || (LINE_SIZE < BPW) || (SETS < 1)) begin : g_bad_cfg
      $error("icache_nway: illegal geometry parameters");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REFILL_REQ, S_REFILL, S_FLUSH} state_t;

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a >> OFF_BITS) & ADDR_WIDTH'(SETS - 1));
  endfunction

  function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_WIDTH-1:0] a);
    return WORD_W'((a >> BYTE_BITS) & ADDR_WIDTH'(WPL - 1));
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] a);
    return TAG_W'(a >> (OFF_BITS + IDX_BITS));
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t state_q, state_d;

  // Storage: valid bits and RR pointers are control state (reset); tags/data are not.
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAY_W-1:0]      rr_q    [SETS];
  logic [TAG_W-1:0]      tag_q   [WAYS][SETS];
  logic [DATA_WIDTH-1:0] data_q  [WAYS][SETS][WPL];

  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [WAY_W-1:0]      victim_q;
  logic                  all_valid_q;
  logic [WORD_W-1:0]     beat_q;
  logic [IDX_W-1:0]      flush_idx_q;
  logic                  pending_q;
  logic                  flush_done_q;
  logic [31:0]           hit_cnt_q, miss_cnt_q;

  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_word;
  logic [TAG_W-1:0]  req_tag;
  logic [WAYS-1:0]   hit_vec;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic              accept;
  logic              last_beat;
  logic              last_set;

  assign req_idx   = addr_idx(req_addr_q);
  assign req_word  = addr_word(req_addr_q);
  assign req_tag   = addr_tag(req_addr_q);
  assign accept    = cpu_req_valid_i && cpu_req_ready_o;
  assign last_beat = mem_rsp_valid_i && (beat_q == WORD_W'(WPL - 1));
  assign last_set  = (flush_idx_q == IDX_W'(SETS - 1));
  assign hit       = |hit_vec;

  assign flush_done_o      = flush_done_q;
  assign perf_hit_count_o  = hit_cnt_q;
  assign perf_miss_count_o = miss_cnt_q;

  // Tag compare across all ways of the addressed set
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  // Victim: fill holes first, otherwise follow the set's round-robin pointer
  always_comb begin
    logic found;
    found  = 1'b0;
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[req_idx][w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) victim = rr_q[req_idx];
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (flush_i || pending_q)  state_d = S_FLUSH;
        else if (cpu_req_valid_i)  state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (!hit)        state_d = S_REFILL_REQ;
        else if (accept) state_d = S_LOOKUP;
        else             state_d = S_IDLE;
      end
      S_REFILL_REQ: if (mem_req_ready_i) state_d = S_REFILL;
      S_REFILL:     if (last_beat)       state_d = S_IDLE;
      S_FLUSH:      if (last_set)        state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cpu_req_ready_o = 1'b0;
    cpu_rsp_valid_o = 1'b0;
    cpu_rsp_data_o  = '0;
    cpu_rsp_hit_o   = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_req_addr_o  = '0;
    case (state_q)
      S_IDLE: cpu_req_ready_o = !flush_i && !pending_q;
      S_LOOKUP: begin
        if (hit) begin
          cpu_rsp_valid_o = 1'b1;
          cpu_rsp_hit_o   = 1'b1;
          cpu_rsp_data_o  = data_q[hit_way][req_idx][req_word];
          cpu_req_ready_o = !flush_i && !pending_q;
        end
      end
      S_REFILL_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = (req_addr_q >> OFF_BITS) << OFF_BITS;
      end
      S_REFILL: begin
        // Critical word goes straight from the memory bus to the fetch stage
        if (mem_rsp_valid_i && (beat_q == req_word)) begin
          cpu_rsp_valid_o = 1'b1;
          cpu_rsp_data_o  = mem_rsp_data_i;
        end
      end
      default: ;
    endcase
    // Reset holds the FSM in IDLE, where ready would otherwise be high
    if (rst_i) cpu_req_ready_o = 1'b0;
  end

  // Control state: valid bits, RR pointers, refill/flush bookkeeping, counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
      victim_q     <= '0;
      all_valid_q  <= 1'b0;
      beat_q       <= '0;
      flush_idx_q  <= '0;
      pending_q    <= 1'b0;
      flush_done_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      flush_done_q <= (state_q == S_FLUSH) && last_set;

      // A flush seen while the cache is busy is remembered until IDLE
      if ((state_q == S_IDLE) && (state_d == S_FLUSH))
        pending_q <= 1'b0;
      else if (flush_i && ((state_q == S_LOOKUP) || (state_q == S_REFILL_REQ) ||
                           (state_q == S_REFILL)))
        pending_q <= 1'b1;

      case (state_q)
        S_LOOKUP: begin
          if (hit) begin
            hit_cnt_q <= sat_inc(hit_cnt_q);
          end else begin
            miss_cnt_q  <= sat_inc(miss_cnt_q);
            victim_q    <= victim;
            all_valid_q <= &valid_q[req_idx];
            beat_q      <= '0;
          end
        end
        S_REFILL: begin
          if (mem_rsp_valid_i) begin
            beat_q <= beat_q + WORD_W'(1);
            if (last_beat) begin
              valid_q[req_idx][victim_q] <= 1'b1;
              // Pointer only advances when the victim was chosen by it
              if (all_valid_q)
                rr_q[req_idx] <= (WAYS == 1) ? '0 : rr_q[req_idx] + WAY_W'(1);
            end
          end
        end
        S_FLUSH: begin
          valid_q[flush_idx_q] <= '0;
          rr_q[flush_idx_q]    <= '0;
          flush_idx_q          <= last_set ? '0 : flush_idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Datapath: request address, tag and data arrays
  always_ff @(posedge clk_i) begin
    if (accept) req_addr_q <= cpu_req_addr_i;
    if ((state_q == S_REFILL) && mem_rsp_valid_i) begin
      data_q[victim_q][req_idx][beat_q] <= mem_rsp_data_i;
      if (last_beat) tag_q[victim_q][req_idx] <= req_tag;
    end
  end

  a_single_way_hit: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == S_LOOKUP) |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: self-checking bench for icache_nway (256 B, 16 B lines,
//   2 ways -> 8 sets, 4 words per line). A behavioural memory answers
//   refill requests with beats derived from the address; responses are
//   checked against a scoreboard queue filled when each fetch is driven.
module tb_icache_nway;

  localparam int WPL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req_valid = 1'b0;
  logic [31:0] cpu_req_addr  = '0;
  logic        cpu_req_ready;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rsp_data;
  logic        cpu_rsp_hit;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        flush = 1'b0;
  logic        flush_done;
  logic [31:0] hit_count, miss_count;

  icache_nway #(.CACHE_SIZE(256), .LINE_SIZE(16), .WAYS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_valid_i(cpu_req_valid), .cpu_req_addr_i(cpu_req_addr), .cpu_req_ready_o(cpu_req_ready),
    .cpu_rsp_valid_o(cpu_rsp_valid), .cpu_rsp_data_o(cpu_rsp_data), .cpu_rsp_hit_o(cpu_rsp_hit),
    .mem_req_valid_o(mem_req_valid), .mem_req_addr_o(mem_req_addr), .mem_req_ready_i(mem_req_ready),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_data_i(mem_rsp_data),
    .flush_i(flush), .flush_done_o(flush_done),
    .perf_hit_count_o(hit_count), .perf_miss_count_o(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        hit;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        hit;
  } vec_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cur_beat = -1;
  int          rsp_beat = -1;
  int          mem_reqs = 0;
  logic [31:0] last_req_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ {a[31:2], 2'b00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Memory model: accept a request one cycle after it appears, then stream the line
  initial begin
    int mst;
    mst = 0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      case (mst)
        0: begin
          mem_rsp_valid = 1'b0;
          cur_beat = -1;
          if (mem_req_valid === 1'b1) begin
            last_req_addr = mem_req_addr;
            mem_reqs++;
            mem_req_ready = 1'b1;
            mst = 1;
          end
        end
        1: begin
          mem_req_ready = 1'b0;
          mem_rsp_valid = 1'b1;
          cur_beat = 0;
          mem_rsp_data = mem_word(last_req_addr);
          mst = 2;
        end
        default: begin
          if (cur_beat == WPL - 1) begin
            mem_rsp_valid = 1'b0;
            cur_beat = -1;
            mst = 0;
          end else begin
            cur_beat++;
            mem_rsp_data = mem_word(last_req_addr + 32'(4 * cur_beat));
          end
        end
      endcase
    end
  end

  // Response monitor: every response must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && cpu_rsp_valid === 1'b1) begin
      rsp_beat = mem_rsp_valid ? cur_beat : -1;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got data %h hit %b, required no response", cpu_rsp_data, cpu_rsp_hit);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_data", cpu_rsp_data, e.data);
        check("rsp_hit", {31'd0, cpu_rsp_hit}, {31'd0, e.hit});
      end
    end
  end

  task automatic wait_accept(input string name);
    bit ok;
    ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (cpu_req_ready === 1'b1) ok = 1;
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && cpu_req_ready === 1'b1) ok = 1;
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  // Single fetch; a miss must produce exactly one line request for its line
  task automatic fetch(input logic [31:0] a, input logic exp_hit);
    int reqs0;
    reqs0 = mem_reqs;
    sb.push_back('{mem_word(a), exp_hit});
    @(posedge clk); #1;
    cpu_req_valid = 1'b1;
    cpu_req_addr  = a;
    wait_accept("fetch_accept");
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    wait_idle("fetch_done");
    check("mem_req_count", 32'(mem_reqs - reqs0), exp_hit ? 32'd0 : 32'd1);
    if (!exp_hit) check("mem_req_addr", last_req_addr, {a[31:4], 4'h0});
  endtask

  task automatic wait_beat(input int b, input string name);
    bit ok;
    ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (mem_rsp_valid === 1'b1 && cur_beat == b) ok = 1;
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    vec_t tbl[8];
    bit   seen;
    tbl = '{'{32'h100, 1'b1}, '{32'h184, 1'b0}, '{32'h20C, 1'b0}, '{32'h188, 1'b1},
            '{32'h104, 1'b0}, '{32'h200, 1'b1}, '{32'h180, 1'b0}, '{32'h10C, 1'b1}};

    // Reset state
    #2;
    check("rst_ready", {31'd0, cpu_req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, cpu_rsp_valid}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req_valid}, 32'd0);
    check("rst_flush_done", {31'd0, flush_done}, 32'd0);
    check("rst_hits", hit_count, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, cpu_req_ready}, 32'd1);

    // 1: cold fetch, critical word on the third beat
    fetch(32'h108, 1'b0);
    check("t1_crit_beat", 32'(rsp_beat), 32'd2);
    check("t1_miss", miss_count, 32'd1);
    check("t1_hit", hit_count, 32'd0);

    // 2: back-to-back hits, one per cycle
    sb.push_back('{mem_word(32'h108), 1'b1});
    sb.push_back('{mem_word(32'h10C), 1'b1});
    @(posedge clk); #1;
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h108;
    @(negedge clk);
    check("t2_ready0", {31'd0, cpu_req_ready}, 32'd1);
    @(posedge clk); #1;
    cpu_req_addr = 32'h10C;
    @(negedge clk);
    check("t2_ready1", {31'd0, cpu_req_ready}, 32'd1);
    check("t2_rsp_t1", {31'd0, cpu_rsp_valid}, 32'd1);
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    @(negedge clk);
    check("t2_rsp_t2", {31'd0, cpu_rsp_valid}, 32'd1);
    @(negedge clk);
    check("t2_hits", hit_count, 32'd2);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // 3: set-0 conflicts exercising fill-holes-first then round-robin
    foreach (tbl[i]) fetch(tbl[i].addr, tbl[i].hit);
    check("t3_hits", hit_count, 32'd6);
    check("t3_miss", miss_count, 32'd5);

    // 4: one-cycle flush in IDLE
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("t4_ready_flush", {31'd0, cpu_req_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t4_ready_sweep", {31'd0, cpu_req_ready}, 32'd0);
      check("t4_done_early", {31'd0, flush_done}, 32'd0);
    end
    @(negedge clk);
    check("t4_done", {31'd0, flush_done}, 32'd1);
    check("t4_ready_back", {31'd0, cpu_req_ready}, 32'd1);
    @(negedge clk);
    check("t4_done_pulse", {31'd0, flush_done}, 32'd0);
    fetch(32'h108, 1'b0);

    // 5: flush during refill beat 1
    sb.push_back('{mem_word(32'h308), 1'b0});
    @(posedge clk); #1;
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h308;
    wait_accept("t5_accept");
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    wait_beat(1, "t5_beat1");
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (flush_done === 1'b1) seen = 1;
    end
    check("t5_flush_done", {31'd0, seen}, 32'd1);
    check("t5_crit_fwd", 32'(sb.size()), 32'd0);
    fetch(32'h308, 1'b0);
    check("t5_miss", miss_count, 32'd8);

    // 6: reset during refill beat 2, stray beat afterwards
    sb.push_back('{mem_word(32'h100), 1'b0});
    @(posedge clk); #1;
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h100;
    wait_accept("t6_accept");
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    wait_beat(2, "t6_beat2");
    rst = 1'b1;
    #1;
    check("t6_rst_ready", {31'd0, cpu_req_ready}, 32'd0);
    check("t6_rst_rsp", {31'd0, cpu_rsp_valid}, 32'd0);
    check("t6_rst_mem_req", {31'd0, mem_req_valid}, 32'd0);
    check("t6_rst_miss", miss_count, 32'd0);
    check("t6_rst_hit", hit_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_stray_beat", {31'd0, mem_rsp_valid}, 32'd1);
    check("t6_ready", {31'd0, cpu_req_ready}, 32'd1);
    check("t6_no_rsp", {31'd0, cpu_rsp_valid}, 32'd0);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
    fetch(32'h100, 1'b0);
    fetch(32'h100, 1'b1);
    check("t6_miss", miss_count, 32'd1);
    check("t6_hit", hit_count, 32'd1);

    repeat (3) @(negedge clk);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
